mem_bus_arbiter: RTL and testbench

//  Shares one single-port 64-bit memory bus between the instruction-fetch requester
//  and the load/store requester of the CPU core. Fixed LS-over-IF priority with a

---
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (IF, LS) arbiter onto one single-port 64-bit memory bus, LS priority with IF starvation bound.
// Latency: gnt cycle N, mem_req from N+1, rvalid one cycle after mem_ack; requesters hold req until gnt, one transaction in flight.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_wen,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [7:0]        ls_wmask,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              req_wen_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [7:0]        req_wmask_q;
    logic              if_rvalid_q, ls_rvalid_q;
    logic [31:0]       if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic idle, starve, ls_grant, if_grant, busy, ack_if, ack_ls;

    // Grants are gated by reset so nothing is offered while rst is asserted.
    assign idle     = rst && (state_q == IDLE);
    assign starve   = if_req && (streak_q == SW'(STARVE_MAX));
    assign ls_grant = idle && ls_req && !starve;
    assign if_grant = idle && if_req && !ls_grant;
    assign busy     = (state_q != IDLE);
    assign ack_if   = (state_q == BUSY_IF) && mem_ack;
    assign ack_ls   = (state_q == BUSY_LS) && mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ls_grant) begin
                    state_d = BUSY_LS;
                end else if (if_grant) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (!if_req || if_grant) begin
            streak_q <= '0;
        end else if (ls_grant && (streak_q != SW'(STARVE_MAX))) begin
            streak_q <= streak_q + SW'(1);
        end
    end

    // Request registers; fetches always go out as clean reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end else if (ls_grant) begin
            req_addr_q  <= ls_addr;
            req_wen_q   <= ls_wen;
            req_wdata_q <= ls_wdata;
            req_wmask_q <= ls_wmask;
        end else if (if_grant) begin
            req_addr_q  <= if_addr;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= ack_if;
            ls_rvalid_q <= ack_ls;
            if (ack_if) begin
                if_rdata_q <= req_addr_q[2] ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
            end
            // Store completions leave the previous load data visible.
            if (ack_ls && !req_wen_q) begin
                ls_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (busy) begin
            mem_req   = 1'b1;
            mem_wen   = req_wen_q;
            mem_addr  = req_addr_q;
            mem_wdata = req_wdata_q;
            mem_wmask = req_wmask_q;
        end
    end

    assign if_gnt    = if_grant;
    assign ls_gnt    = ls_grant;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: queued requesters, latency-programmable memory responder,
// cycle-level grant/bus model and a response scoreboard.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int SMAX = 4;

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } ls_op_t;

    typedef struct packed {
        logic        is_if;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    typedef struct packed {
        logic        is_if;
        logic        wen;
        logic [63:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic        mem_req, mem_wen, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] if_todo[$];
    ls_op_t      ls_todo[$];
    rsp_t        exp_q[$];

    int   ack_dly  = 0;
    int   noise_en = 0;
    int   phase4   = 0;
    int   run_ls   = 0;
    int   p4_if    = 0;
    logic if_gnt_s = 1'b0;
    logic ls_gnt_s = 1'b0;

    logic        m_busy = 1'b0;
    logic        m_rv_if = 1'b0;
    logic        m_rv_ls = 1'b0;
    int          m_streak = 0;
    logic [63:0] last_ls = '0;
    txn_t        m_cur = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_func(input logic [63:0] a);
        if (a == 64'h8000_0004) return 64'h1111_2222_3333_4444;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0] + 32'h17};
    endfunction

    task automatic push_ls(input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask);
        ls_op_t op;
        op.wen = wen; op.addr = addr; op.wdata = wdata; op.wmask = wmask;
        ls_todo.push_back(op);
    endtask

    // IF requester: holds req and address until the grant is seen.
    initial begin
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (if_req && if_gnt_s) begin if_req = 1'b0; if_addr = '0; end
            if (!if_req && if_todo.size() > 0) begin
                if_addr = if_todo.pop_front();
                if_req  = 1'b1;
            end
        end
    end

    initial begin
        ls_op_t op;
        ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        forever begin
            @(posedge clk); #1;
            if (ls_req && ls_gnt_s) begin
                ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
            end
            if (!ls_req && ls_todo.size() > 0) begin
                op = ls_todo.pop_front();
                ls_wen = op.wen; ls_addr = op.addr; ls_wdata = op.wdata; ls_wmask = op.wmask;
                ls_req = 1'b1;
            end
        end
    end

    // Memory: acks ack_dly cycles after mem_req rises; optional stray acks while idle.
    initial begin
        int cnt;
        cnt = 0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                mem_ack = 1'b0; cnt = 0;
            end else if (mem_req) begin
                if (cnt >= ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = mem_func(mem_addr); cnt = 0;
                end else begin
                    mem_ack = 1'b0; cnt++;
                end
            end else begin
                cnt = 0;
                mem_ack = (noise_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    always @(negedge clk) begin : mon
        logic        e_ls, e_if;
        logic [63:0] d;
        rsp_t        r;
        if (!rst) begin
            m_busy = 1'b0; m_rv_if = 1'b0; m_rv_ls = 1'b0; m_streak = 0;
            last_ls = '0; exp_q.delete(); if_gnt_s = 1'b0; ls_gnt_s = 1'b0;
        end else begin
            e_ls = !m_busy && ls_req && !(if_req && m_streak == SMAX);
            e_if = !m_busy && if_req && !e_ls;
            chk("ls_gnt", 64'(ls_gnt), 64'(e_ls));
            chk("if_gnt", 64'(if_gnt), 64'(e_if));
            chk("gnt_exclusive", 64'(ls_gnt & if_gnt), 64'd0);
            chk("mem_req", 64'(mem_req), 64'(m_busy));
            if (m_busy) begin
                chk("mem_addr", mem_addr, m_cur.addr);
                chk("mem_wen", 64'(mem_wen), 64'(m_cur.wen));
                chk("mem_wdata", mem_wdata, m_cur.wdata);
                chk("mem_wmask", 64'(mem_wmask), 64'(m_cur.wmask));
            end else begin
                chk("mem_addr_idle", mem_addr, 64'd0);
                chk("mem_wdata_idle", mem_wdata, 64'd0);
                chk("mem_ctl_idle", 64'({mem_wen, mem_wmask}), 64'd0);
            end
            chk("if_rvalid", 64'(if_rvalid), 64'(m_rv_if));
            chk("ls_rvalid", 64'(ls_rvalid), 64'(m_rv_ls));
            if (if_rvalid || ls_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_owner", 64'(if_rvalid), 64'(r.is_if));
                    if (r.is_if) chk("if_rdata", 64'(if_rdata), r.data);
                    else if (!r.wen) last_ls = r.data;
                end
            end
            chk("ls_rdata", ls_rdata, last_ls);
            if (phase4 != 0) begin
                if (ls_gnt) run_ls++;
                if (if_gnt) begin
                    chk("starve_run", 64'(run_ls), 64'(SMAX));
                    run_ls = 0; p4_if++;
                end
            end
            m_rv_if = 1'b0; m_rv_ls = 1'b0;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 1'b0;
                    d = mem_func(m_cur.addr);
                    r.is_if = m_cur.is_if; r.wen = m_cur.wen;
                    if (m_cur.is_if) r.data = m_cur.addr[2] ? {32'd0, d[63:32]} : {32'd0, d[31:0]};
                    else r.data = d;
                    exp_q.push_back(r);
                    if (m_cur.is_if) m_rv_if = 1'b1; else m_rv_ls = 1'b1;
                end
            end else if (e_ls) begin
                m_busy = 1'b1;
                m_cur.is_if = 1'b0; m_cur.wen = ls_wen; m_cur.addr = ls_addr;
                m_cur.wdata = ls_wdata; m_cur.wmask = ls_wmask;
            end else if (e_if) begin
                m_busy = 1'b1;
                m_cur.is_if = 1'b1; m_cur.wen = 1'b0; m_cur.addr = if_addr;
                m_cur.wdata = '0; m_cur.wmask = '0;
            end
            if (!if_req || e_if) m_streak = 0;
            else if (e_ls && m_streak < SMAX) m_streak++;
            if_gnt_s = if_gnt; ls_gnt_s = ls_gnt;
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((if_todo.size() > 0 || ls_todo.size() > 0 || if_req || ls_req || m_busy ||
                exp_q.size() > 0) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) chk(tag, 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_mem_req(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk(tag, 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        // 1: requests pending during reset must not leak through
        if_todo.push_back(64'h0000_0100);
        push_ls(1'b0, 64'h0000_2000, 64'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("t1_gnts_in_rst", 64'({if_gnt, ls_gnt}), 64'd0);
        chk("t1_mem_in_rst", 64'({mem_req, mem_wen, mem_wmask}), 64'd0);
        chk("t1_mem_addr_in_rst", mem_addr | mem_wdata, 64'd0);
        chk("t1_rsp_in_rst", 64'({if_rvalid, ls_rvalid}) | 64'(if_rdata) | ls_rdata, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t1_first_ls_gnt", 64'(ls_gnt), 64'd1);
        chk("t1_first_no_if", 64'(if_gnt), 64'd0);
        drain("t1_drain_timeout");

        // 2: IF fetch of upper word with two-cycle memory
        ack_dly = 2;
        @(posedge clk); #2 if_todo.push_back(64'h8000_0004);
        wait_mem_req("t2_req_timeout");
        chk("t2_mem_addr", mem_addr, 64'h8000_0004);
        chk("t2_mem_wen", 64'(mem_wen), 64'd0);
        n = 0;
        while (!if_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("t2_rvalid_latency", 64'(n), 64'd3);
        chk("t2_if_rdata", 64'(if_rdata), 64'h1111_2222);
        drain("t2_drain_timeout");

        // 3: simultaneous requests, IF granted in the LS rvalid cycle
        ack_dly = 0; noise_en = 1;
        @(posedge clk); #2;
        if_todo.push_back(64'h0000_7000);
        push_ls(1'b0, 64'h0000_7100, 64'd0, 8'd0);
        @(posedge clk); @(negedge clk);
        chk("t3_ls_first", 64'(ls_gnt), 64'd1);
        chk("t3_if_waits", 64'(if_gnt), 64'd0);
        n = 0;
        while (!ls_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("t3_if_gnt_at_rvalid", 64'(if_gnt), 64'd1);
        drain("t3_drain_timeout");

        // 4: saturated LS traffic with IF pending; IF forced every STARVE_MAX grants
        @(posedge clk); #2;
        phase4 = 1; run_ls = 0; p4_if = 0;
        for (int i = 0; i < 12; i++)
            push_ls(1'(i % 3 == 0), 64'h3000 + 64'(i * 8), {$urandom, $urandom}, 8'($urandom));
        for (int i = 0; i < 3; i++) if_todo.push_back(64'h9000 + 64'(i * 4));
        drain("t4_drain_timeout");
        phase4 = 0;
        chk("t4_if_grants", 64'(p4_if), 64'd3);

        // 5: masked store; completion only on the LS side
        ack_dly = 1;
        @(posedge clk); #2 push_ls(1'b1, 64'h8000_1000, 64'hDEAD_BEEF_0BAD_F00D, 8'h0F);
        wait_mem_req("t5_req_timeout");
        chk("t5_mem_wen", 64'(mem_wen), 64'd1);
        chk("t5_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0BAD_F00D);
        chk("t5_mem_wmask", 64'(mem_wmask), 64'h0F);
        n = 0;
        while (!ls_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("t5_ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk("t5_if_quiet", 64'(if_rvalid), 64'd0);
        drain("t5_drain_timeout");

        // 6: reset in the middle of a slow LS load
        ack_dly = 6;
        @(posedge clk); #2 push_ls(1'b0, 64'h0000_4000, 64'd0, 8'd0);
        wait_mem_req("t6_req_timeout");
        @(posedge clk); #3 rst = 1'b0;
        #1 chk("t6_mem_req_drop", 64'(mem_req), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_no_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        end
        ack_dly = 1;
        @(posedge clk); #2;
        if_todo.push_back(64'h0000_5008);
        push_ls(1'b0, 64'h0000_6000, 64'd0, 8'd0);
        drain("t6_drain_timeout");
        chk("t6_ls_rdata_after", ls_rdata, mem_func(64'h0000_6000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
